// File: rtl/posit_stream_checker.sv
// posit_stream_checker: aligns expected posit results with a unit's output
// (fixed-latency delay line or valid-handshake FIFO), computes |exp - dut|,
// flags results outside a tolerance or with a lone NaR, and keeps running
// statistics (counts, largest diff, index of first failure, sticky FIFO flags).
module posit_stream_checker #(
  parameter int             N       = 32,
  parameter int             LATENCY = 4,
  parameter int             DEPTH   = 16,
  parameter int             MODE    = 0,
  parameter logic [N-1:0]   TOL     = '0,
  parameter int             CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             exp_valid,
  input  logic [N-1:0]     exp_data,
  input  logic             dut_valid,
  input  logic [N-1:0]     dut_data,
  output logic             cmp_valid,
  output logic [N-1:0]     cmp_diff,
  output logic             cmp_error,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] cmp_count,
  output logic [N-1:0]     max_diff,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_vld,
  output logic             overflow,
  output logic             underflow
);

  // NaR: sign bit set, all other bits clear.
  localparam logic [N-1:0]     NAR     = {1'b1, {(N-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Capture stage: the matched (expected, observed) pair waiting to be compared.
  logic         cap_valid;
  logic [N-1:0] cap_exp;
  logic [N-1:0] cap_dut;

  // One-cycle events raised by the alignment front end (FIFO mode only).
  logic ovf_evt;
  logic udf_evt;

  generate
    if (MODE == 0) begin : g_fixed
      // Delay line: stage 0 is loaded from the input, stage LATENCY-1 is the
      // expectation whose unit result is on dut_data this cycle.
      logic         dl_valid [LATENCY];
      logic [N-1:0] dl_data  [LATENCY];
      logic         unused_dut_valid;

      // The handshake valid carries no meaning for fixed-latency units.
      assign unused_dut_valid = dut_valid;
      assign ovf_evt = 1'b0;
      assign udf_evt = 1'b0;

      // First delay-line stage: sample the incoming expectation.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          dl_valid[0] <= 1'b0;
          dl_data[0]  <= '0;
        end else begin
          dl_valid[0] <= exp_valid;
          dl_data[0]  <= exp_data;
        end
      end

      for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
        // Remaining delay-line stages: shift valid and data one step.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            dl_valid[gi] <= 1'b0;
            dl_data[gi]  <= '0;
          end else begin
            dl_valid[gi] <= dl_valid[gi-1];
            dl_data[gi]  <= dl_data[gi-1];
          end
        end
      end

      // Pair the oldest expectation with the unit output of this cycle.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cap_valid <= 1'b0;
          cap_exp   <= '0;
          cap_dut   <= '0;
        end else begin
          cap_valid <= dl_valid[LATENCY-1];
          if (dl_valid[LATENCY-1]) begin
            cap_exp <= dl_data[LATENCY-1];
            cap_dut <= dut_data;
          end
        end
      end
    end else begin : g_fifo
      localparam int AW = $clog2(DEPTH);
      localparam logic [AW-1:0] PTR_ONE = AW'(1);
      localparam logic [AW:0]   CNT1    = (AW+1)'(1);

      logic [N-1:0]  mem [DEPTH];
      logic [AW-1:0] wr_ptr;
      logic [AW-1:0] rd_ptr;
      logic [AW:0]   count;
      logic          full;
      logic          empty;
      logic          pop_ok;
      logic          push_ok;

      // DEPTH is a power of two, so the count MSB alone marks "full".
      assign full    = count[AW];
      assign empty   = (count == '0);
      assign pop_ok  = dut_valid && !empty;
      // A full FIFO still accepts a push when a pop frees the head slot.
      assign push_ok = exp_valid && (!full || pop_ok);
      assign ovf_evt = exp_valid && full && !pop_ok;
      assign udf_evt = dut_valid && empty;

      // Storage array; read-first behaviour lets push and pop share a slot
      // when full (wr_ptr == rd_ptr).
      always_ff @(posedge clk) begin
        if (push_ok) begin
          mem[wr_ptr] <= exp_data;
        end
      end

      // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end else begin
          if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
          if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
          case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT1;
            2'b01:   count <= count - CNT1;
            default: count <= count;
          endcase
        end
      end

      // Registered read of the head entry alongside the unit output.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cap_valid <= 1'b0;
          cap_exp   <= '0;
          cap_dut   <= '0;
        end else begin
          cap_valid <= pop_ok;
          if (pop_ok) begin
            cap_exp <= mem[rd_ptr];
            cap_dut <= dut_data;
          end
        end
      end
    end
  endgenerate

  logic [N-1:0] diff;
  logic         exp_nar;
  logic         dut_nar;
  logic         err;

  // Unsigned absolute difference and pass/fail decision for the captured pair.
  always_comb begin
    diff    = '0;
    exp_nar = (cap_exp == NAR);
    dut_nar = (cap_dut == NAR);
    if (cap_exp > cap_dut) begin
      diff = cap_exp - cap_dut;
    end else begin
      diff = cap_dut - cap_exp;
    end
    // A lone NaR is always wrong, whatever the numeric distance.
    err = (diff > TOL) || (exp_nar ^ dut_nar);
  end

  // Result registers: per-comparison outputs follow the pair even under clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmp_valid <= 1'b0;
      cmp_diff  <= '0;
      cmp_error <= 1'b0;
    end else begin
      cmp_valid <= cap_valid;
      if (cap_valid) begin
        cmp_diff  <= diff;
        cmp_error <= err;
      end
    end
  end

  // Statistics and sticky flags; clear takes priority over a completing comparison.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      err_count     <= '0;
      cmp_count     <= '0;
      max_diff      <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      if (ovf_evt) overflow  <= 1'b1;
      if (udf_evt) underflow <= 1'b1;
      if (cap_valid) begin
        if (cmp_count != CNT_MAX) cmp_count <= cmp_count + CNT_ONE;
        if (err && (err_count != CNT_MAX)) err_count <= err_count + CNT_ONE;
        if (diff > max_diff) max_diff <= diff;
        if (err && !first_err_vld) begin
          first_err_idx <= cmp_count;
          first_err_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_posit_stream_checker.sv
// Directed bench for posit_stream_checker: four instances (fixed latency with
// TOL 0 and TOL 2, FIFO depth 4, FIFO with maximal tolerance) share the input
// stimulus; each scenario resets and then observes its own instance.
module tb_posit_stream_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        exp_valid;
  logic [31:0] exp_data;
  logic        dut_valid;
  logic [31:0] dut_data;

  logic        cmp_valid     [4];
  logic [31:0] cmp_diff      [4];
  logic        cmp_error     [4];
  logic [31:0] err_count     [4];
  logic [31:0] cmp_count     [4];
  logic [31:0] max_diff      [4];
  logic [31:0] first_err_idx [4];
  logic        first_err_vld [4];
  logic        overflow      [4];
  logic        underflow     [4];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  posit_stream_checker #(.N(32), .LATENCY(4), .DEPTH(16), .MODE(0), .TOL(32'd0), .CNT_W(32)) u0 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .exp_valid(exp_valid), .exp_data(exp_data), .dut_valid(dut_valid), .dut_data(dut_data),
    .cmp_valid(cmp_valid[0]), .cmp_diff(cmp_diff[0]), .cmp_error(cmp_error[0]),
    .err_count(err_count[0]), .cmp_count(cmp_count[0]), .max_diff(max_diff[0]),
    .first_err_idx(first_err_idx[0]), .first_err_vld(first_err_vld[0]),
    .overflow(overflow[0]), .underflow(underflow[0]));

  posit_stream_checker #(.N(32), .LATENCY(4), .DEPTH(16), .MODE(0), .TOL(32'd2), .CNT_W(32)) u1 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .exp_valid(exp_valid), .exp_data(exp_data), .dut_valid(dut_valid), .dut_data(dut_data),
    .cmp_valid(cmp_valid[1]), .cmp_diff(cmp_diff[1]), .cmp_error(cmp_error[1]),
    .err_count(err_count[1]), .cmp_count(cmp_count[1]), .max_diff(max_diff[1]),
    .first_err_idx(first_err_idx[1]), .first_err_vld(first_err_vld[1]),
    .overflow(overflow[1]), .underflow(underflow[1]));

  posit_stream_checker #(.N(32), .LATENCY(4), .DEPTH(4), .MODE(1), .TOL(32'd0), .CNT_W(32)) u2 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .exp_valid(exp_valid), .exp_data(exp_data), .dut_valid(dut_valid), .dut_data(dut_data),
    .cmp_valid(cmp_valid[2]), .cmp_diff(cmp_diff[2]), .cmp_error(cmp_error[2]),
    .err_count(err_count[2]), .cmp_count(cmp_count[2]), .max_diff(max_diff[2]),
    .first_err_idx(first_err_idx[2]), .first_err_vld(first_err_vld[2]),
    .overflow(overflow[2]), .underflow(underflow[2]));

  posit_stream_checker #(.N(32), .LATENCY(4), .DEPTH(4), .MODE(1), .TOL(32'hFFFF_FFFF), .CNT_W(32)) u3 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .exp_valid(exp_valid), .exp_data(exp_data), .dut_valid(dut_valid), .dut_data(dut_data),
    .cmp_valid(cmp_valid[3]), .cmp_diff(cmp_diff[3]), .cmp_error(cmp_error[3]),
    .err_count(err_count[3]), .cmp_count(cmp_count[3]), .max_diff(max_diff[3]),
    .first_err_idx(first_err_idx[3]), .first_err_vld(first_err_vld[3]),
    .overflow(overflow[3]), .underflow(underflow[3]));

  // Advance one rising edge; inputs are changed and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clear = 1'b0;
    exp_valid = 1'b0; exp_data = '0; dut_valid = 1'b0; dut_data = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({cmp_valid[k], cmp_diff[k], cmp_error[k], err_count[k], cmp_count[k], max_diff[k],
           first_err_idx[k], first_err_vld[k], overflow[k], underflow[k]} !== '0)
        $display("FAIL reset_outputs inst%0d got valid=%b diff=%h err=%b cnt=%0d/%0d ovf=%b udf=%b, required all zero",
                 k, cmp_valid[k], cmp_diff[k], cmp_error[k], err_count[k], cmp_count[k], overflow[k], underflow[k]);
      else passed++;
    end
    $display("reset: outputs of all instances checked");
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      exp_valid = (i < 8);
      exp_data  = 32'h4000_0000;
      dut_data  = (i >= 4 && i < 12) ? 32'h4000_0000 : 32'h0;
      tick();
      checks++;
      if (cmp_valid[0] !== (i >= 5 && i < 13))
        $display("FAIL stream_valid edge%0d got %b required %b", i, cmp_valid[0], (i >= 5 && i < 13));
      else passed++;
      $display("stream edge %0d: cmp_valid=%b diff=%h", i, cmp_valid[0], cmp_diff[0]);
    end
    checks++;
    if (cmp_count[0] !== 32'd8) $display("FAIL stream_cmp_count got %0d required 8", cmp_count[0]); else passed++;
    checks++;
    if (err_count[0] !== 32'd0) $display("FAIL stream_err_count got %0d required 0", err_count[0]); else passed++;
    checks++;
    if (max_diff[0] !== 32'd0) $display("FAIL stream_max_diff got %h required 0", max_diff[0]); else passed++;
  endtask

  task automatic test_tolerance();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      exp_valid = (i < 2);
      exp_data  = 32'h3F00_0010;
      dut_data  = (i == 4) ? 32'h3F00_0012 : (i == 5) ? 32'h3F00_000C : 32'h0;
      tick();
      if (i == 5) begin
        checks++;
        if ({cmp_valid[1], cmp_error[1], cmp_diff[1]} !== {1'b1, 1'b0, 32'd2})
          $display("FAIL tol_pass got valid=%b err=%b diff=%h required 1/0/2", cmp_valid[1], cmp_error[1], cmp_diff[1]);
        else passed++;
      end
      if (i == 6) begin
        checks++;
        if ({cmp_valid[1], cmp_error[1], cmp_diff[1]} !== {1'b1, 1'b1, 32'd4})
          $display("FAIL tol_fail got valid=%b err=%b diff=%h required 1/1/4", cmp_valid[1], cmp_error[1], cmp_diff[1]);
        else passed++;
        checks++;
        if (err_count[1] !== 32'd1) $display("FAIL tol_err_count got %0d required 1", err_count[1]); else passed++;
        checks++;
        if ({first_err_vld[1], first_err_idx[1]} !== {1'b1, 32'd1})
          $display("FAIL tol_first_err got vld=%b idx=%0d required 1/1", first_err_vld[1], first_err_idx[1]);
        else passed++;
        checks++;
        if (max_diff[1] !== 32'd4) $display("FAIL tol_max_diff got %h required 4", max_diff[1]); else passed++;
      end
    end
    $display("tolerance: cmp_count=%0d err_count=%0d", cmp_count[1], err_count[1]);
  endtask

  task automatic test_fifo_flags();
    logic [31:0] push_vals [5];
    logic [31:0] pop_vals  [4];
    logic [31:0] want_diff [4];
    push_vals = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    pop_vals  = '{32'h11, 32'h22, 32'h30, 32'h44};
    want_diff = '{32'h0, 32'h0, 32'h3, 32'h0};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      exp_valid = (i < 5);
      exp_data  = (i < 5) ? push_vals[i] : 32'h0;
      dut_valid = (i >= 5 && i <= 9);
      dut_data  = (i >= 5 && i <= 8) ? pop_vals[i-5] : 32'h0;
      tick();
      if (i == 3) begin
        checks++;
        if (overflow[2] !== 1'b0) $display("FAIL fifo_no_ovf_at_full got %b required 0", overflow[2]); else passed++;
      end
      if (i == 4) begin
        checks++;
        if (overflow[2] !== 1'b1) $display("FAIL fifo_ovf got %b required 1", overflow[2]); else passed++;
      end
      if (i >= 6 && i <= 9) begin
        checks++;
        if ({cmp_valid[2], cmp_diff[2]} !== {1'b1, want_diff[i-6]})
          $display("FAIL fifo_pop%0d got valid=%b diff=%h required 1/%h", i-6, cmp_valid[2], cmp_diff[2], want_diff[i-6]);
        else passed++;
      end
      if (i == 8) begin
        checks++;
        if (underflow[2] !== 1'b0) $display("FAIL fifo_early_udf got %b required 0", underflow[2]); else passed++;
      end
      if (i == 9) begin
        checks++;
        if (underflow[2] !== 1'b1) $display("FAIL fifo_udf got %b required 1", underflow[2]); else passed++;
        checks++;
        if ({err_count[2], first_err_idx[2]} !== {32'd1, 32'd2})
          $display("FAIL fifo_err_stats got err=%0d idx=%0d required 1/2", err_count[2], first_err_idx[2]);
        else passed++;
      end
      if (i == 10) begin
        checks++;
        if ({cmp_valid[2], cmp_count[2], overflow[2]} !== {1'b0, 32'd4, 1'b1})
          $display("FAIL fifo_after_udf got valid=%b cnt=%0d ovf=%b required 0/4/1", cmp_valid[2], cmp_count[2], overflow[2]);
        else passed++;
      end
      $display("fifo edge %0d: cmp_valid=%b diff=%h ovf=%b udf=%b", i, cmp_valid[2], cmp_diff[2], overflow[2], underflow[2]);
    end
  endtask

  task automatic test_back_to_back_full();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      exp_valid = (i <= 4);
      exp_data  = (i < 4) ? 32'hA0 + 32'(i) : 32'hB0;
      dut_valid = (i >= 4);
      dut_data  = (i <= 7) ? 32'hA0 + 32'(i - 4) : (i == 8) ? 32'hB4 : 32'h0;
      tick();
      if (i == 4) begin
        checks++;
        if (overflow[2] !== 1'b0) $display("FAIL full_pushpop_ovf got %b required 0", overflow[2]); else passed++;
      end
      if (i >= 5 && i <= 8) begin
        checks++;
        if ({cmp_valid[2], cmp_diff[2]} !== {1'b1, 32'h0})
          $display("FAIL full_pop%0d got valid=%b diff=%h required 1/0", i-5, cmp_valid[2], cmp_diff[2]);
        else passed++;
      end
      if (i == 8) begin
        checks++;
        if (underflow[2] !== 1'b0) $display("FAIL full_early_udf got %b required 0", underflow[2]); else passed++;
      end
      if (i == 9) begin
        checks++;
        if ({cmp_valid[2], cmp_error[2], cmp_diff[2]} !== {1'b1, 1'b1, 32'd4})
          $display("FAIL full_late_entry got valid=%b err=%b diff=%h required 1/1/4", cmp_valid[2], cmp_error[2], cmp_diff[2]);
        else passed++;
        checks++;
        if ({cmp_count[2], err_count[2], first_err_idx[2]} !== {32'd5, 32'd1, 32'd4})
          $display("FAIL full_stats got cnt=%0d err=%0d idx=%0d required 5/1/4", cmp_count[2], err_count[2], first_err_idx[2]);
        else passed++;
        checks++;
        if ({underflow[2], overflow[2]} !== 2'b10)
          $display("FAIL full_flags got udf=%b ovf=%b required 1/0", underflow[2], overflow[2]);
        else passed++;
      end
      $display("full edge %0d: cmp_valid=%b diff=%h", i, cmp_valid[2], cmp_diff[2]);
    end
  endtask

  task automatic test_nar();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_valid = (i <= 1);
      exp_data  = (i == 0) ? 32'h8000_0000 : 32'h1234_5678;
      dut_valid = (i == 1 || i == 2);
      dut_data  = (i == 1) ? 32'h7FFF_FFFF : 32'h0;
      tick();
      if (i == 2) begin
        checks++;
        if ({cmp_valid[3], cmp_error[3], cmp_diff[3]} !== {1'b1, 1'b1, 32'd1})
          $display("FAIL nar_error got valid=%b err=%b diff=%h required 1/1/1", cmp_valid[3], cmp_error[3], cmp_diff[3]);
        else passed++;
      end
      if (i == 3) begin
        checks++;
        if ({cmp_error[3], cmp_diff[3]} !== {1'b0, 32'h1234_5678})
          $display("FAIL nar_tol_pass got err=%b diff=%h required 0/12345678", cmp_error[3], cmp_diff[3]);
        else passed++;
        checks++;
        if ({err_count[3], cmp_count[3], max_diff[3]} !== {32'd1, 32'd2, 32'h1234_5678})
          $display("FAIL nar_stats got err=%0d cnt=%0d max=%h required 1/2/12345678", err_count[3], cmp_count[3], max_diff[3]);
        else passed++;
      end
      $display("nar edge %0d: cmp_valid=%b err=%b diff=%h", i, cmp_valid[3], cmp_error[3], cmp_diff[3]);
    end
  endtask

  task automatic test_midreset_clear();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_valid = 1'b1; exp_data = 32'h4000_0000; dut_data = 32'h0;
      tick();
    end
    rst_n = 1'b0; exp_valid = 1'b0;
    tick();
    checks++;
    if ({cmp_valid[0], cmp_diff[0], cmp_error[0], err_count[0], cmp_count[0], max_diff[0],
         first_err_idx[0], first_err_vld[0], overflow[0], underflow[0]} !== '0)
      $display("FAIL midreset_outputs got valid=%b cnt=%0d err=%0d, required all zero", cmp_valid[0], cmp_count[0], err_count[0]);
    else passed++;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (cmp_valid[0] !== 1'b0) $display("FAIL midreset_stale edge%0d got %b required 0", i, cmp_valid[0]); else passed++;
    end
    checks++;
    if (cmp_count[0] !== 32'd0) $display("FAIL midreset_count got %0d required 0", cmp_count[0]); else passed++;
    for (int i = 0; i < 7; i++) begin
      exp_valid = (i < 2);
      exp_data  = 32'h4000_0000;
      dut_data  = (i == 4) ? 32'h4000_0002 : (i == 5) ? 32'h4000_0001 : 32'h0;
      clear     = (i == 6);
      tick();
      if (i == 5) begin
        checks++;
        if ({cmp_count[0], err_count[0], first_err_vld[0]} !== {32'd1, 32'd1, 1'b1})
          $display("FAIL preclear_stats got cnt=%0d err=%0d vld=%b required 1/1/1", cmp_count[0], err_count[0], first_err_vld[0]);
        else passed++;
      end
      if (i == 6) begin
        checks++;
        if ({cmp_valid[0], cmp_error[0], cmp_diff[0]} !== {1'b1, 1'b1, 32'd1})
          $display("FAIL clear_cmp got valid=%b err=%b diff=%h required 1/1/1", cmp_valid[0], cmp_error[0], cmp_diff[0]);
        else passed++;
        checks++;
        if ({cmp_count[0], err_count[0], max_diff[0], first_err_idx[0], first_err_vld[0]} !== '0)
          $display("FAIL clear_stats got cnt=%0d err=%0d max=%h vld=%b required all zero",
                   cmp_count[0], err_count[0], max_diff[0], first_err_vld[0]);
        else passed++;
      end
    end
    clear = 1'b0;
    $display("midreset/clear: cmp_count=%0d err_count=%0d", cmp_count[0], err_count[0]);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_tolerance();
    test_fifo_flags();
    test_back_to_back_full();
    test_nar();
    test_midreset_clear();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/posit_stream_checker.md
# posit_stream_checker

Synthesizable latency-aligned result checker for the posit arithmetic units (positadd_*, positmult_*). It holds expected posit results issued alongside unit stimulus, aligns them with the unit's output, and computes the unsigned absolute difference. It flags mismatches beyond a tolerance and keeps running statistics. It generalises the fixed 32-bit, latency-4 offline comparison into a parametrised on-chip block. The block supports fixed-latency and valid-handshake units of any width.

## Interface
- N, 32, posit width in bits
- LATENCY, 4, unit latency in cycles (MODE 0 only), ≥1
- DEPTH, 16, expected-value FIFO depth (MODE 1 only), power of two, ≥2
- MODE, 0, 0 = fixed latency (delay line), 1 = valid handshake (FIFO)
- TOL, 0, largest |diff| still counted as a pass
- CNT_W, 32, width of statistics counters
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- clear  in  1  synchronous clear of statistics and sticky flags; pipeline and FIFO contents kept
- exp_valid  in  1  expected result present this cycle
- exp_data  in  N  expected posit
- dut_valid  in  1  unit output valid (ignored in MODE 0)
- dut_data  in  N  unit output posit
- cmp_valid  out  1  one-cycle pulse: comparison result registered
- cmp_diff  out  N  |exp − dut|, unsigned
- cmp_error  out  1  current comparison failed
- err_count  out  CNT_W  failed comparisons, saturating
- cmp_count  out  CNT_W  total comparisons, saturating
- max_diff  out  N  largest cmp_diff since reset/clear
- first_err_idx  out  CNT_W  cmp_count value (pre-increment) of the first failure
- first_err_vld  out  1  first_err_idx is valid
- overflow  out  1  sticky: push dropped, FIFO full (MODE 1)
- underflow  out  1  sticky: dut_valid with FIFO empty (MODE 1)

## Operation
- Reset (rst_n=0 at an edge): every output is 0. Delay-line valids are 0. FIFO pointers and count are 0. Reset mid-stream discards all in-flight expectations.
- clear=1: err_count, cmp_count, max_diff, first_err_idx, first_err_vld, overflow, underflow → 0. If a comparison completes in the same cycle, clear wins and the comparison is not counted. cmp_valid, cmp_diff and cmp_error still update.
- MODE 0:
  - exp_valid/exp_data shift through a LATENCY-stage delay line of valid+data.
  - When stage LATENCY's valid is 1, dut_data is sampled as the matching output.
  - dut_valid is ignored.
- MODE 1:
  - exp_valid pushes exp_data into the FIFO.
  - dut_valid pops the FIFO head and compares it with dut_data.
  - There is no bypass: an entry pushed in cycle t can be popped from t+1 on.
  - Push when full, with no pop in the same cycle: entry is dropped and overflow is set.
  - Push and pop in the same cycle when full: both are accepted, count unchanged.
  - Pop when empty: no comparison and underflow is set. A same-cycle push still enqueues.
  - Pointers wrap modulo DEPTH.
- Comparison:
  - diff = (exp > dut) ? exp − dut : dut − exp, on unsigned N-bit values.
  - error = (diff > TOL) OR (exactly one of exp/dut is NaR, i.e. 1 followed by N−1 zeros).
  - Exactly one NaR is an error even when TOL covers the diff.
- Statistics:
  - cmp_count increments on every comparison.
  - err_count increments on every error.
  - Both counters hold at all-ones.
  - max_diff updates when diff > max_diff.
  - On the first error with first_err_vld=0: first_err_idx ← cmp_count (pre-increment) and first_err_vld ← 1.

## Timing
- MODE 0: exp_valid at edge t is compared with dut_data sampled at edge t+LATENCY. cmp_valid/cmp_diff/cmp_error are visible after edge t+LATENCY+1. Counters and flags are visible the same cycle.
- MODE 1: dut_valid at edge t with a non-empty FIFO gives cmp_* after edge t+1.
- Throughput: one comparison per cycle, sustained, in both modes.
- overflow and underflow assert after the offending edge and stay set until reset or clear.

## Test plan
- MODE 0, LATENCY=4, TOL=0: push 0x40000000 every cycle for 8 cycles, driving dut_data=0x40000000 four cycles later → 8 cmp_valid pulses, first pulse 5 cycles after the first push, err_count=0, cmp_count=8, max_diff=0.
- MODE 0, TOL=2: expected 0x3F000010. Drive dut 0x3F000012 on the first comparison, then 0x3F00000C on the second → first passes with diff=2; second fails with diff=4; err_count=1, first_err_idx=1, max_diff=4.
- MODE 1, DEPTH=4: push 5 entries with no pops → overflow=1 after the 5th push. Then pop 4 → 4 comparisons against the first 4 entries. A 5th pop → underflow=1, cmp_count stays 4.
- MODE 1: full FIFO, push and pop in the same cycle → no overflow, count stays 4. Pushed value is compared 4 pops later.
- NaR: exp=0x80000000, dut=0x7FFFFFFF, TOL=0xFFFFFFFF → cmp_error=1 despite the tolerance.
- Mid-stream rst_n=0 for one cycle with 3 in flight (MODE 0) → no cmp_valid from pre-reset pushes, all outputs 0. Then clear asserted during a comparison → counters 0, cmp_valid=1.
